// File: rtl/ir_program_loader.sv
// ir_program_loader: receives a length-prefixed, XOR-checksummed program over UART and writes it to instruction memory
module ir_program_loader #(
  parameter int CLK_DIV = 434,
  parameter int ADDR_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  output logic [ADDR_W-1:0] ir_m_addr,
  output logic [15:0]       ir_m_data,
  output logic              ir_m_rw,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR} st_t;

  rx_t rs_q;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic rx_s, tick_full, tick_half, byte_valid, frame_err;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
  assign rx_s       = sync_q[1];
  assign tick_full  = cnt_q == CW'(CLK_DIV - 1);
  assign tick_half  = cnt_q == CW'(CLK_DIV / 2 - 1);
  assign byte_valid = rs_q == R_STOP && tick_full && rx_s;
  assign frame_err  = rs_q == R_STOP && tick_full && !rx_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 3'b111;
      rs_q   <= R_HUNT;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
    end else begin
      sync_q <= {sync_q[1:0], rx};
      case (rs_q)
        R_HUNT: begin
          cnt_q <= '0;
          if (sync_q[2] && !rx_s) rs_q <= R_START;
        end
        R_START: begin
          cnt_q <= tick_half ? '0 : cnt_q + CW'(1);
          bit_q <= '0;
          if (tick_half) rs_q <= rx_s ? R_HUNT : R_DATA;
        end
        R_DATA: begin
          cnt_q <= tick_full ? '0 : cnt_q + CW'(1);
          if (tick_full) begin
            sh_q  <= {rx_s, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) rs_q <= R_STOP;
          end
        end
        default: begin
          cnt_q <= tick_full ? '0 : cnt_q + CW'(1);
          if (tick_full) rs_q <= R_HUNT;
        end
      endcase
    end
  end

  st_t st_q, st_d;
  logic [15:0] len_q, idx_q, n;
  logic [7:0] hi_q, ck_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0] data_q;
  logic rw_q, hold_q, busy_q, done_q, err_q, idle_like, rcv, last;

  assign n         = {len_q[15:8], sh_q};
  assign idle_like = st_q inside {IDLE, DONE, ERROR};
  assign rcv       = st_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
  assign last      = idx_q + 16'd1 == len_q;

  always_comb begin
    st_d = st_q;
    if (idle_like && start) st_d = LEN_HI;
    else if (st_q == WRITE) st_d = last ? CHECK : DATA_HI;
    else if (rcv && frame_err) st_d = ERROR;
    else if (rcv && byte_valid)
      case (st_q)
        LEN_HI:  st_d = LEN_LO;
        LEN_LO:  st_d = n == 16'd0 ? CHECK : ({1'b0, n} > CAP ? ERROR : DATA_HI);
        DATA_HI: st_d = DATA_LO;
        DATA_LO: st_d = WRITE;
        default: st_d = sh_q == ck_q ? DONE : ERROR;
      endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      len_q  <= '0;
      idx_q  <= '0;
      hi_q   <= '0;
      ck_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      rw_q   <= 1'b0;
      hold_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      rw_q   <= st_d == WRITE;
      hold_q <= !(st_d inside {IDLE, DONE});
      busy_q <= !(st_d inside {IDLE, DONE, ERROR});
      done_q <= st_d == DONE;
      err_q  <= st_d == ERROR;
      if (idle_like && start) begin
        ck_q  <= '0;
        idx_q <= '0;
      end
      if (st_q == WRITE) idx_q <= idx_q + 16'd1;
      if (byte_valid)
        case (st_q)
          LEN_HI:  len_q[15:8] <= sh_q;
          LEN_LO:  len_q[7:0] <= sh_q;
          DATA_HI: begin
            hi_q <= sh_q;
            ck_q <= ck_q ^ sh_q;
          end
          DATA_LO: begin
            ck_q   <= ck_q ^ sh_q;
            addr_q <= idx_q[ADDR_W-1:0];
            data_q <= {hi_q, sh_q};
          end
          default: ;
        endcase
    end
  end

  assign ir_m_addr = addr_q;
  assign ir_m_data = data_q;
  assign ir_m_rw   = rw_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = err_q;
endmodule
